// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver slice.
// Optional parity support is selected with the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_t;

    // Level of the serial line when nothing is being sent
    localparam logic RX_IDLE_LEVEL = 1'b1;

    function automatic int tick_cnt_width(input int oversample);
        return $clog2(oversample);
    endfunction

    function automatic int bit_cnt_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

    // Number of oversampling ticks from a bit edge to its centre
    function automatic int half_bit_ticks(input int oversample);
        return oversample / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle line level.
module uart_rx_sync
    import uart_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rxs
);

    logic meta;

    // Two-stage capture of the raw line into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RX_IDLE_LEVEL;
            rxs  <= RX_IDLE_LEVEL;
        end else begin
            meta <= rx;
            rxs  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: framing FSM, oversampled bit timing, shift register and
// output holding register with valid/ready delivery.
// Define UART_RX_PARITY_EN to build the parity bit check; otherwise parity_err is 0.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 baud_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = tick_cnt_width(OVERSAMPLE);
    localparam int BW = bit_cnt_width(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(half_bit_ticks(OVERSAMPLE) - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic                 rxs;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 frame_flag;
    logic                 par_flag;
    logic                 done;
    logic                 at_half;
    logic                 at_full;
    logic                 last_stop;
    logic                 load_word;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .rxs (rxs)
    );

    assign at_half   = baud_tick && (state == START) && (tick_cnt == HALF_LAST);
    assign at_full   = baud_tick && (tick_cnt == TICK_LAST);
    assign last_stop = at_full && (state == STOP) && (bit_cnt == STOP_LAST);
    assign load_word = done && (!rx_valid || rx_ready);
    assign busy      = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decisions, all taken on the synchronized line
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (!rxs) state_nxt = START;
            START:    if (at_half) state_nxt = rxs ? IDLE : DATA;
            DATA: begin
                if (at_full && (bit_cnt == DATA_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:   if (at_full) state_nxt = STOP;
`endif
            STOP:     if (last_stop) state_nxt = (frame_flag || !rxs) ? BRK_WAIT : IDLE;
            BRK_WAIT: if (rxs) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Tick counter: half bit in START, full bits afterwards, held at 0 while waiting
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state == BRK_WAIT) tick_cnt <= '0;
        else if (at_half || at_full)                   tick_cnt <= '0;
        else if (baud_tick)                            tick_cnt <= tick_cnt + 1'b1;
    end

    // Bit counter shared by the data and stop phases
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            bit_cnt <= '0;
        end else if (at_full && state == DATA) begin
            bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
        end else if (at_full && state == STOP) begin
            bit_cnt <= (bit_cnt == STOP_LAST) ? '0 : bit_cnt + 1'b1;
        end
    end

    // LSB-first assembly: each data sample enters at the MSB side
    always_ff @(posedge clk) begin
        if (rst)                          shift_reg <= '0;
        else if (at_full && state == DATA) shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
    end

    // Per-word frame flag, cleared when a new start edge is seen
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && !rxs)) frame_flag <= 1'b0;
        else if (at_full && state == STOP && !rxs) frame_flag <= 1'b1;
    end

    // One-cycle marker for the cycle after the last stop sample
    always_ff @(posedge clk) begin
        if (rst) done <= 1'b0;
        else     done <= last_stop;
    end

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    // Parity mismatch: XOR of data and parity bit must equal the odd/even selection
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && !rxs)) par_flag <= 1'b0;
        else if (at_full && state == PARITY) par_flag <= rxs ^ (^shift_reg) ^ PAR_ODD;
    end

    // Parity status held alongside the delivered word
    always_ff @(posedge clk) begin
        if (rst)            parity_err <= 1'b0;
        else if (load_word) parity_err <= par_flag;
    end
`else
    assign par_flag   = 1'b0;
    assign parity_err = par_flag;
`endif

    // Output holding register, handshake and overrun reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= done && !load_word;
            if (load_word) begin
                rx_data   <= shift_reg;
                frame_err <= frame_flag;
                rx_valid  <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame (8 data bits, 16x oversampling, 1 stop bit).
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;
    logic       busy;

    int nChecks = 0;
    int nErrors = 0;
    int tickDiv = 0;
    int ovCount = 0;
    logic [9:0] wordQ[$];

    uart_rx_frame #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS),
        .STOP_BITS  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .baud_tick   (baud_tick),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Oversampling tick every third clock, changed away from the active edge
    always @(negedge clk) begin
        tickDiv   <= (tickDiv == 2) ? 0 : tickDiv + 1;
        baud_tick <= (tickDiv == 2);
    end

    // Record every completed transfer as {frame_err, parity_err, rx_data}
    always @(negedge clk) begin
        if (rx_valid && rx_ready) wordQ.push_back({frame_err, parity_err, rx_data});
        if (overrun_err) ovCount <= ovCount + 1;
    end

    // Global time limit
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitTicks(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge clk);
            if (baud_tick) c++;
        end
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk);
        rx = b;
        waitTicks(OS);
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit, then the stop bit.
    // The line is left at the stop level so a break can be extended by the caller.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(data[i]);
`ifdef UART_RX_PARITY_EN
        sendBit(parBit);
`else
        if (parBit) begin end
`endif
        sendBit(stopBit);
    endtask

    task automatic waitWords(input string tag, input int n);
        int budget;
        budget = 3000;
        while (wordQ.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput(tag, wordQ.size(), n);
    endtask

    function automatic logic [9:0] getWord(input int i);
        if (i < wordQ.size()) return wordQ[i];
        return 10'h3FF;
    endfunction

    task automatic setReady(input logic v);
        @(posedge clk);
        #1 rx_ready = v;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_data"},    rx_data,     0);
        checkOutput({tag, "_valid"},   rx_valid,    0);
        checkOutput({tag, "_frame"},   frame_err,   0);
        checkOutput({tag, "_parity"},  parity_err,  0);
        checkOutput({tag, "_overrun"}, overrun_err, 0);
        checkOutput({tag, "_busy"},    busy,        0);
    endtask

    initial begin
        int base;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        waitTicks(4);

        // Two clean 8N1 words with the consumer always ready
        setReady(1'b1);
        applyStimulus(8'h55, 1'b1, 1'b0);
        applyStimulus(8'hA3, 1'b1, 1'b1);
        waitTicks(8);
        waitWords("twoWords_count", 2);
        checkOutput("word0_55", getWord(0), 10'h055);
        checkOutput("word1_A3", getWord(1), 10'h0A3);

        // Start-bit glitch: 4 ticks low, then back to idle
        base = wordQ.size();
        @(negedge clk);
        rx = 1'b0;
        waitTicks(2);
        @(negedge clk);
        checkOutput("glitch_busyHigh", busy, 1);
        waitTicks(2);
        @(negedge clk);
        rx = 1'b1;
        waitTicks(8);
        @(negedge clk);
        checkOutput("glitch_busy",    busy,        0);
        checkOutput("glitch_valid",   rx_valid,    0);
        checkOutput("glitch_frame",   frame_err,   0);
        checkOutput("glitch_overrun", overrun_err, 0);
        checkOutput("glitch_noWord",  wordQ.size(), base);

        // Framing error followed by a 3-bit break
        base = wordQ.size();
        applyStimulus(8'h3C, 1'b0, 1'b0);
        waitTicks(3 * OS);
        @(negedge clk);
        checkOutput("break_busyHigh", busy, 1);
        rx = 1'b1;
        waitTicks(6);
        @(negedge clk);
        checkOutput("break_busyLow", busy, 0);
        checkOutput("break_oneWord", wordQ.size(), base + 1);
        checkOutput("break_word3C",  getWord(base), 10'h23C);

        // Overrun: second word arrives while the first is still held
        base = wordQ.size();
        ovCount = 0;
        setReady(1'b0);
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        waitTicks(8);
        @(negedge clk);
        checkOutput("ovr_valid",   rx_valid, 1);
        checkOutput("ovr_data11",  rx_data,  8'h11);
        checkOutput("ovr_pulses",  ovCount,  1);
        setReady(1'b1);
        repeat (4) @(negedge clk);
        checkOutput("ovr_transfers", wordQ.size(), base + 1);
        checkOutput("ovr_word11",    getWord(base), 10'h011);
        checkOutput("ovr_validLow",  rx_valid, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct
        base = wordQ.size();
        applyStimulus(8'h07, 1'b1, 1'b0);
        applyStimulus(8'h07, 1'b1, 1'b1);
        waitTicks(8);
        waitWords("par_count", base + 2);
        checkOutput("par_bad",  getWord(base),     10'h107);
        checkOutput("par_good", getWord(base + 1), 10'h007);
`endif

        // Reset in the middle of the data phase abandons the frame
        base = wordQ.size();
        @(negedge clk);
        rx = 1'b0;
        waitTicks(OS + 40);
        @(negedge clk);
        rx = 1'b1;
        waitTicks(2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkIdleOutputs("midReset");
        waitTicks(4);
        applyStimulus(8'h9E, 1'b1, 1'b0);
        waitTicks(8);
        waitWords("midReset_count", base + 1);
        checkOutput("midReset_word9E", getWord(base), 10'h09E);
        waitTicks(OS);
        checkOutput("midReset_onlyOne", wordQ.size(), base + 1);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
